// File: rtl/vme_cmd_pkg.sv
// Shared types and constants for the VME command responder.
// Stats register addresses are only decoded when VME_CMD_STATS_EN is defined.
package vme_cmd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  localparam int unsigned RD_BIT  = 25;
  localparam int unsigned WR_BIT  = 24;
  localparam int unsigned ERR_BIT = 31;
  localparam int unsigned TMO_BIT = 30;

  localparam logic [15:0] DEAD_DATA = 16'hDEAD;

  localparam logic [3:0]  STATS_DEV        = 4'hF;
  localparam logic [11:0] STATS_LEGAL_ADDR = 12'h000;
  localparam logic [11:0] STATS_ERR_ADDR   = 12'h004;
  localparam logic [11:0] STATS_CLR_ADDR   = 12'h008;

  function automatic logic [31:0] pack_resp(input logic err, input logic tmo,
                                            input logic [15:0] data);
    logic [31:0] w_word;
    w_word          = 32'h0;
    w_word[ERR_BIT] = err;
    w_word[TMO_BIT] = tmo;
    w_word[15:0]    = data;
    return w_word;
  endfunction

endpackage

// File: rtl/vme_cmd_responder_timeout.sv
// Bus-access watchdog: counts enabled cycles and flags when TIMEOUT is reached.
module vme_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == W'(TIMEOUT));

endmodule

// File: rtl/vme_cmd_responder.sv
// VME command responder: one strobe/ack device access per accepted command.
// Define VME_CMD_STATS_EN to decode device F internally as command/error counters.
module vme_cmd_responder
  import vme_cmd_pkg::*;
#(
  parameter logic [7:0]  BOARD_ID = 8'hA8,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] vme_cmd_reg,
  input  logic [31:0] vme_dat_reg_in,
  output logic        vme_cmd_rd,
  output logic        vme_dat_wr,
  output logic [31:0] vme_dat_reg_out,
  output logic [3:0]  dev_num,
  output logic [11:0] dev_addr,
  output logic [15:0] dev_wdata,
  output logic        dev_we,
  output logic        dev_strobe,
  input  logic        dev_ack,
  input  logic [15:0] dev_rdata
);

  state_e      r_state, w_state_d;
  logic        r_cmd_rd, r_dat_wr, r_strobe, r_dev_we, r_internal;
  logic [3:0]  r_dev_num;
  logic [11:0] r_dev_addr;
  logic [15:0] r_dev_wdata;
  logic [31:0] r_dat_out, w_resp_d;
  logic        w_accept, w_legal_in, w_internal_in, w_internal_d, w_expired;
  logic        w_unused;

  assign w_unused   = ^{vme_dat_reg_in[31:16], vme_cmd_reg[31:26]};
  assign w_accept   = start && r_cmd_rd;
  assign w_legal_in = (vme_cmd_reg[23:16] == BOARD_ID) &&
                      (vme_cmd_reg[RD_BIT] ^ vme_cmd_reg[WR_BIT]);

`ifdef VME_CMD_STATS_EN
  logic [15:0] r_legal_cnt, r_err_cnt;
  logic        w_count_legal, w_count_err, w_stats_clr;
  assign w_internal_in = (vme_cmd_reg[15:12] == STATS_DEV);
`else
  assign w_internal_in = 1'b0;
`endif

  assign w_internal_d = w_accept ? w_internal_in : r_internal;

  vme_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state != StAccess),
    .i_en      (r_state == StAccess),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_d = r_state;
    w_resp_d  = r_dat_out;
`ifdef VME_CMD_STATS_EN
    w_count_legal = 1'b0;
    w_count_err   = 1'b0;
    w_stats_clr   = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_legal_in) begin
            w_state_d = StAccess;
          end else begin
            w_state_d = StResp;
            w_resp_d  = pack_resp(1'b1, 1'b0, 16'h0);
`ifdef VME_CMD_STATS_EN
            w_count_err = 1'b1;
`endif
          end
        end
      end
      StAccess: begin
`ifdef VME_CMD_STATS_EN
        if (r_internal) begin
          // Counter values are read before this command's own increment lands.
          w_state_d     = StResp;
          w_count_legal = 1'b1;
          if (!r_dev_we && r_dev_addr == STATS_LEGAL_ADDR) begin
            w_resp_d = pack_resp(1'b0, 1'b0, r_legal_cnt);
          end else if (!r_dev_we && r_dev_addr == STATS_ERR_ADDR) begin
            w_resp_d = pack_resp(1'b0, 1'b0, r_err_cnt);
          end else if (r_dev_we && r_dev_addr == STATS_CLR_ADDR) begin
            w_resp_d    = pack_resp(1'b0, 1'b0, r_dev_wdata);
            w_stats_clr = 1'b1;
          end else begin
            w_resp_d    = pack_resp(1'b1, 1'b0, 16'h0);
            w_count_err = 1'b1;
          end
        end else
`endif
        if (dev_ack) begin
          // Ack takes priority over a timeout expiring in the same cycle.
          w_state_d = StResp;
          w_resp_d  = pack_resp(1'b0, 1'b0, r_dev_we ? r_dev_wdata : dev_rdata);
`ifdef VME_CMD_STATS_EN
          w_count_legal = 1'b1;
`endif
        end else if (w_expired) begin
          w_state_d = StResp;
          w_resp_d  = pack_resp(1'b1, 1'b1, DEAD_DATA);
`ifdef VME_CMD_STATS_EN
          w_count_legal = 1'b1;
          w_count_err   = 1'b1;
`endif
        end
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cmd_rd    <= 1'b0;
      r_dat_wr    <= 1'b0;
      r_strobe    <= 1'b0;
      r_dev_we    <= 1'b0;
      r_internal  <= 1'b0;
      r_dev_num   <= '0;
      r_dev_addr  <= '0;
      r_dev_wdata <= '0;
      r_dat_out   <= '0;
    end else begin
      r_state   <= w_state_d;
      r_cmd_rd  <= (w_state_d == StIdle);
      r_dat_wr  <= (w_state_d == StResp);
      r_strobe  <= (w_state_d == StAccess) && !w_internal_d;
      r_dat_out <= w_resp_d;
      if (w_accept) begin
        r_dev_num   <= vme_cmd_reg[15:12];
        r_dev_addr  <= vme_cmd_reg[11:0];
        r_dev_we    <= vme_cmd_reg[WR_BIT];
        r_dev_wdata <= vme_dat_reg_in[15:0];
        r_internal  <= w_internal_in;
      end
    end
  end

`ifdef VME_CMD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_legal_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (w_stats_clr) begin
      r_legal_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_count_legal && r_legal_cnt != 16'hFFFF) r_legal_cnt <= r_legal_cnt + 16'd1;
      if (w_count_err && r_err_cnt != 16'hFFFF)     r_err_cnt   <= r_err_cnt + 16'd1;
    end
  end
`endif

  assign vme_cmd_rd      = r_cmd_rd;
  assign vme_dat_wr      = r_dat_wr;
  assign vme_dat_reg_out = r_dat_out;
  assign dev_num         = r_dev_num;
  assign dev_addr        = r_dev_addr;
  assign dev_wdata       = r_dev_wdata;
  assign dev_we          = r_dev_we;
  assign dev_strobe      = r_strobe;

endmodule

// File: tb/tb_vme_cmd_responder.sv
// Directed bench for vme_cmd_responder; stats checks run when VME_CMD_STATS_EN is defined.
module tb_vme_cmd_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] vme_cmd_reg = '0;
  logic [31:0] vme_dat_reg_in = '0;
  logic        vme_cmd_rd, vme_dat_wr, dev_we, dev_strobe;
  logic [31:0] vme_dat_reg_out;
  logic [3:0]  dev_num;
  logic [11:0] dev_addr;
  logic [15:0] dev_wdata;
  logic        dev_ack = 1'b0;
  logic [15:0] dev_rdata = '0;

  int n_total = 0;
  int n_bad   = 0;

  vme_cmd_responder dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .vme_cmd_reg     (vme_cmd_reg),
    .vme_dat_reg_in  (vme_dat_reg_in),
    .vme_cmd_rd      (vme_cmd_rd),
    .vme_dat_wr      (vme_dat_wr),
    .vme_dat_reg_out (vme_dat_reg_out),
    .dev_num         (dev_num),
    .dev_addr        (dev_addr),
    .dev_wdata       (dev_wdata),
    .dev_we          (dev_we),
    .dev_strobe      (dev_strobe),
    .dev_ack         (dev_ack),
    .dev_rdata       (dev_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cmd;
    logic [31:0] din;
    int          ack_dly;
    logic [15:0] rdata;
    logic [31:0] exp_out;
    int          exp_lat;
    logic        exp_stb;
    logic        exp_we;
    logic [3:0]  exp_num;
    logic [11:0] exp_addr;
    logic [15:0] exp_wd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 20; k++) begin
      if (vme_cmd_rd) break;
      tick();
    end
    chk("wait_ready", {31'h0, vme_cmd_rd}, 32'h1);
  endtask

  // Issues one command and plays the device side; lat counts cycles from start to vme_dat_wr.
  task automatic run_cmd(input logic [31:0] cmd, input logic [31:0] din, input int ack_dly,
                         input logic [15:0] rd, output int lat, output logic stb,
                         output logic we, output logic [3:0] num, output logic [11:0] addr,
                         output logic [15:0] wd, output logic [31:0] out,
                         output logic rd_at_wr, output logic wr_after, output logic rd_after);
    int s;
    s = 0; lat = -1; stb = 0; we = 0; num = 0; addr = 0; wd = 0; out = 0;
    rd_at_wr = 0; wr_after = 0; rd_after = 0;
    wait_ready();
    start = 1'b1; vme_cmd_reg = cmd; vme_dat_reg_in = din;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      dev_ack = 1'b0;
      if (vme_dat_wr) begin
        lat = k; out = vme_dat_reg_out; rd_at_wr = vme_cmd_rd;
        break;
      end
      if (dev_strobe) begin
        stb = 1'b1; we = dev_we; num = dev_num; addr = dev_addr; wd = dev_wdata;
        if (s == ack_dly) begin
          dev_ack = 1'b1; dev_rdata = rd;
        end
        s++;
      end
      tick();
    end
    dev_ack = 1'b0;
    if (lat > 0) begin
      tick();
      wr_after = vme_dat_wr; rd_after = vme_cmd_rd;
    end
  endtask

  vec_t vecs[9];

  initial begin
    int          lat;
    logic        stb, we, rdw, wra, rda;
    logic [3:0]  num;
    logic [11:0] addr;
    logic [15:0] wd;
    logic [31:0] out;
    int          seen_wr, seen_stb;

    vecs[0] = '{32'h02A8_3010, 32'h0, 2, 16'h1234, 32'h0000_1234, 4, 1'b1, 1'b0, 4'h3, 12'h010, 16'h0};
    vecs[1] = '{32'h01A8_1020, 32'h0000_BEEF, 0, 16'h5555, 32'h0000_BEEF, 2, 1'b1, 1'b1, 4'h1,
                12'h020, 16'hBEEF};
    vecs[2] = '{32'h02A9_3010, 32'h0, 0, 16'h0, 32'h8000_0000, 1, 1'b0, 1'b0, 4'h0, 12'h0, 16'h0};
    vecs[3] = '{32'h03A8_3010, 32'h0, 0, 16'h0, 32'h8000_0000, 1, 1'b0, 1'b0, 4'h0, 12'h0, 16'h0};
    vecs[4] = '{32'h00A8_3010, 32'h0, 0, 16'h0, 32'h8000_0000, 1, 1'b0, 1'b0, 4'h0, 12'h0, 16'h0};
    vecs[5] = '{32'h02A8_2044, 32'h0, -1, 16'h0, 32'hC000_DEAD, 257, 1'b1, 1'b0, 4'h2, 12'h044,
                16'h0};
    vecs[6] = '{32'h02A8_7FFF, 32'h0, 0, 16'hA5A5, 32'h0000_A5A5, 2, 1'b1, 1'b0, 4'h7, 12'hFFF,
                16'h0};
    vecs[7] = '{32'h01A8_5100, 32'h1234_0042, 1, 16'h0, 32'h0000_0042, 3, 1'b1, 1'b1, 4'h5,
                12'h100, 16'h0042};
    // Ack lands in the very cycle the counter reaches TIMEOUT: must count as an ack.
    vecs[8] = '{32'h02A8_6008, 32'h0, 255, 16'h0F0F, 32'h0000_0F0F, 257, 1'b1, 1'b0, 4'h6,
                12'h008, 16'h0};

    // Reset state
    tick(); tick();
    chk("rst.cmd_rd", {31'h0, vme_cmd_rd}, 32'h0);
    chk("rst.dat_wr", {31'h0, vme_dat_wr}, 32'h0);
    chk("rst.strobe", {31'h0, dev_strobe}, 32'h0);
    chk("rst.dat_out", vme_dat_reg_out, 32'h0);
    chk("rst.dev", {dev_num, dev_addr, dev_wdata}, 32'h0);
    rst = 1'b0;
    #1 chk("rel.cmd_rd_low", {31'h0, vme_cmd_rd}, 32'h0);
    tick();
    chk("rel.cmd_rd_high", {31'h0, vme_cmd_rd}, 32'h1);

    for (int i = 0; i < 9; i++) begin
      run_cmd(vecs[i].cmd, vecs[i].din, vecs[i].ack_dly, vecs[i].rdata,
              lat, stb, we, num, addr, wd, out, rdw, wra, rda);
      chk($sformatf("v%0d.out", i), out, vecs[i].exp_out);
      chk($sformatf("v%0d.lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d.strobe", i), {31'h0, stb}, {31'h0, vecs[i].exp_stb});
      chk($sformatf("v%0d.rd_at_wr", i), {31'h0, rdw}, 32'h0);
      chk($sformatf("v%0d.wr_pulse", i), {31'h0, wra}, 32'h0);
      chk($sformatf("v%0d.rd_back", i), {31'h0, rda}, 32'h1);
      chk($sformatf("v%0d.hold", i), vme_dat_reg_out, vecs[i].exp_out);
      if (vecs[i].exp_stb) begin
        chk($sformatf("v%0d.we", i), {31'h0, we}, {31'h0, vecs[i].exp_we});
        chk($sformatf("v%0d.num", i), {28'h0, num}, {28'h0, vecs[i].exp_num});
        chk($sformatf("v%0d.addr", i), {20'h0, addr}, {20'h0, vecs[i].exp_addr});
        if (vecs[i].exp_we) chk($sformatf("v%0d.wdata", i), {16'h0, wd}, {16'h0, vecs[i].exp_wd});
      end
    end

    // start pulsed during ACCESS is dropped
    wait_ready();
    start = 1'b1; vme_cmd_reg = 32'h02A8_3010;
    tick();
    vme_cmd_reg = 32'h01A8_4000; vme_dat_reg_in = 32'h0000_9999;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("busy.strobe%0d", k), {31'h0, dev_strobe}, 32'h1);
      chk($sformatf("busy.addr%0d", k), {20'h0, dev_addr}, 32'h010);
      tick();
    end
    start = 1'b0;
    dev_ack = 1'b1; dev_rdata = 16'h7777;
    tick();
    dev_ack = 1'b0;
    chk("busy.dat_wr", {31'h0, vme_dat_wr}, 32'h1);
    chk("busy.out", vme_dat_reg_out, 32'h0000_7777);
    seen_wr = 0; seen_stb = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (vme_dat_wr) seen_wr++;
      if (dev_strobe) seen_stb++;
    end
    chk("busy.no_second_wr", seen_wr, 0);
    chk("busy.no_second_stb", seen_stb, 0);

    // dev_ack outside ACCESS is ignored
    dev_ack = 1'b1;
    seen_wr = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (vme_dat_wr) seen_wr++;
    end
    dev_ack = 1'b0;
    chk("idle_ack.no_wr", seen_wr, 0);
    chk("idle_ack.hold", vme_dat_reg_out, 32'h0000_7777);

    // Reset mid-access drops the strobe asynchronously
    wait_ready();
    start = 1'b1; vme_cmd_reg = 32'h02A8_3010;
    tick();
    start = 1'b0;
    chk("arst.strobe_pre", {31'h0, dev_strobe}, 32'h1);
    #2 rst = 1'b1;
    #1 chk("arst.strobe_drop", {31'h0, dev_strobe}, 32'h0);
    chk("arst.cmd_rd", {31'h0, vme_cmd_rd}, 32'h0);
    tick();
    rst = 1'b0;
    chk("arst.cmd_rd_rel", {31'h0, vme_cmd_rd}, 32'h0);
    tick();
    chk("arst.cmd_rd_back", {31'h0, vme_cmd_rd}, 32'h1);

`ifdef VME_CMD_STATS_EN
    run_cmd(32'h01A8_F008, 32'h0, 0, 16'h0, lat, stb, we, num, addr, wd, out, rdw, wra, rda);
    chk("st.clr_lat", lat, 2);
    chk("st.clr_nostb", {31'h0, stb}, 32'h0);
    for (int k = 0; k < 3; k++)
      run_cmd(32'h02A8_1000, 32'h0, 0, 16'h0, lat, stb, we, num, addr, wd, out, rdw, wra, rda);
    run_cmd(32'h02A9_1000, 32'h0, 0, 16'h0, lat, stb, we, num, addr, wd, out, rdw, wra, rda);
    run_cmd(32'h02A8_F000, 32'h0, 0, 16'h0, lat, stb, we, num, addr, wd, out, rdw, wra, rda);
    chk("st.legal", out, 32'h0000_0003);
    chk("st.legal_lat", lat, 2);
    chk("st.legal_nostb", {31'h0, stb}, 32'h0);
    run_cmd(32'h02A8_F004, 32'h0, 0, 16'h0, lat, stb, we, num, addr, wd, out, rdw, wra, rda);
    chk("st.err", out, 32'h0000_0001);
    run_cmd(32'h02A8_F00C, 32'h0, 0, 16'h0, lat, stb, we, num, addr, wd, out, rdw, wra, rda);
    chk("st.badaddr", out, 32'h8000_0000);
    run_cmd(32'h02A8_F000, 32'h0, 0, 16'h0, lat, stb, we, num, addr, wd, out, rdw, wra, rda);
    chk("st.legal2", out, 32'h0000_0006);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
